// File: rtl/ram_responder_if.sv
// Memory-side bus types and the request/response interface
// between the memory controller and the RAM responder.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

interface ram_responder_if;
  import cpu_types_pkg::*;

  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;

  modport master (
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramstate
  );

  modport slave (
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramstate
  );
endinterface

// File: rtl/ram_responder.sv
// Word-addressed RAM target: one request at a time, LAT busy
// cycles, then a single ACCESS cycle reported on ramstate.
module ram_responder
  import cpu_types_pkg::*;
#(
  parameter int LAT       = 2,
  parameter int ADDR_BITS = 14
) (
  input  logic            CLK,
  input  logic            nRST,
  ram_responder_if.slave  bus
);

  localparam int         IW    = ADDR_BITS - 2;
  localparam int         DEPTH = 1 << IW;
  localparam logic [3:0] LAT4  = 4'(LAT);

  if (LAT < 0 || LAT > 15) begin : g_lat_chk
    $error("ram_responder: LAT %0d outside 0..15", LAT);
  end

  if (ADDR_BITS < 3 || ADDR_BITS > 31) begin : g_ab_chk
    $error("ram_responder: ADDR_BITS %0d outside 3..31", ADDR_BITS);
  end

  ramstate_t      state;
  logic [3:0]     cnt;
  logic           ren_q;
  logic           wen_q;
  word_t          addr_q;
  word_t          store_q;
  word_t          load_q;

  logic [31:0]    mem [DEPTH];

  logic           req;
  logic           illegal;
  logic           same;
  logic           fwd;
  logic [IW-1:0]  idx_in;
  logic [IW-1:0]  idx_q;
  word_t          rd_new;
  word_t          rd_q;

  assign bus.ramstate = state;
  assign bus.ramload  = load_q;

  always_comb begin
    req     = bus.ramREN | bus.ramWEN;
    illegal = (bus.ramREN & bus.ramWEN)
            | (bus.ramaddr[1:0] != 2'b00)
            | ((bus.ramaddr >> ADDR_BITS) != 32'd0);
    same    = (ren_q == bus.ramREN)
            & (wen_q == bus.ramWEN)
            & (addr_q == bus.ramaddr)
            & (store_q == bus.ramstore);
    idx_in  = bus.ramaddr[ADDR_BITS-1:2];
    idx_q   = addr_q[ADDR_BITS-1:2];
    // a write finishing this cycle commits on the same edge
    // a zero-latency read samples, so hand its data straight over
    fwd     = (state == ACCESS) & wen_q & (idx_q == idx_in);
    rd_new  = fwd ? store_q : mem[idx_in];
    rd_q    = mem[idx_q];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= FREE;
      cnt     <= 4'd0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      addr_q  <= '0;
      store_q <= '0;
      load_q  <= '0;
    end else begin
      unique case (state)
        BUSY: begin
          cnt <= cnt - 4'd1;
          if (!req) begin
            state <= FREE;
          end else if (!same) begin
            ren_q   <= bus.ramREN;
            wen_q   <= bus.ramWEN;
            addr_q  <= bus.ramaddr;
            store_q <= bus.ramstore;
            cnt     <= LAT4;
          end else if (cnt == 4'd1) begin
            state <= ACCESS;
            if (ren_q) load_q <= rd_q;
          end
        end
        default: begin
          if (!req) begin
            state <= FREE;
          end else begin
            ren_q   <= bus.ramREN;
            wen_q   <= bus.ramWEN;
            addr_q  <= bus.ramaddr;
            store_q <= bus.ramstore;
            if (illegal) begin
              state <= ERROR;
            end else if (LAT4 == 4'd0) begin
              state <= ACCESS;
              if (bus.ramREN) load_q <= rd_new;
            end else begin
              state <= BUSY;
              cnt   <= LAT4;
            end
          end
        end
      endcase
    end
  end

  // reset forces state to FREE asynchronously, so a write
  // caught by reset never reaches this edge
  always_ff @(posedge CLK) begin
    if (state == ACCESS && wen_q) mem[idx_q] <= store_q;
  end

endmodule

// File: tb/tb_ram_responder.sv
// Randomized bench for ram_responder: three instances with
// LAT 2, 0 and 3 checked against a word-array reference model.
module tb_ram_responder;
  import cpu_types_pkg::*;

  localparam int LATS [3] = '{2, 0, 3};
  localparam int NW = 80;

  logic      CLK  = 1'b0;
  logic      nRST = 1'b0;

  logic      ren   [3];
  logic      wen   [3];
  word_t     addr  [3];
  word_t     store [3];
  word_t     ld    [3];
  ramstate_t st    [3];

  word_t     mdl     [3][4096];
  word_t     last_ld [3];

  int unsigned pass_n  = 0;
  int unsigned total_n = 0;

  ram_responder_if bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ram_responder #(.LAT(LATS[g]), .ADDR_BITS(14)) u_dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus[g])
    );
    assign bus[g].ramREN   = ren[g];
    assign bus[g].ramWEN   = wen[g];
    assign bus[g].ramaddr  = addr[g];
    assign bus[g].ramstore = store[g];
    assign ld[g] = bus[g].ramload;
    assign st[g] = bus[g].ramstate;
  end

  always #5 CLK = ~CLK;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total_n++;
    if (got === exp) pass_n++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  function automatic bit bad_req(bit r, bit w, word_t a);
    return (r && w) || (a[1:0] != 2'b00) || (a >= 32'h4000);
  endfunction

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  // present a request and follow it to ACCESS/ERROR;
  // inputs stay asserted so a following call runs back-to-back
  task automatic txn(int k, bit r, bit w, word_t a, word_t d);
    ren[k] = r; wen[k] = w; addr[k] = a; store[k] = d;
    if (bad_req(r, w, a)) begin
      step();
      chk($sformatf("d%0d err %h", k, a), st[k], ERROR);
      chk($sformatf("d%0d err_ld", k), ld[k], last_ld[k]);
    end else begin
      for (int i = 0; i < LATS[k]; i++) begin
        step();
        chk($sformatf("d%0d busy %h", k, a), st[k], BUSY);
        chk($sformatf("d%0d busy_ld", k), ld[k], last_ld[k]);
      end
      step();
      chk($sformatf("d%0d access %h", k, a), st[k], ACCESS);
      if (r) begin
        last_ld[k] = mdl[k][a[13:2]];
        chk($sformatf("d%0d rdata %h", k, a), ld[k], last_ld[k]);
      end else begin
        chk($sformatf("d%0d wr_ld", k), ld[k], last_ld[k]);
        mdl[k][a[13:2]] = d;
      end
    end
  endtask

  task automatic idle(int k);
    ren[k] = 1'b0; wen[k] = 1'b0;
    step();
    chk($sformatf("d%0d free", k), st[k], FREE);
    chk($sformatf("d%0d free_ld", k), ld[k], last_ld[k]);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      ren[k] = 1'b0; wen[k] = 1'b0;
      addr[k] = '0; store[k] = '0;
      last_ld[k] = '0;
    end

    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d rst_state", k), st[k], FREE);
      chk($sformatf("d%0d rst_load", k), ld[k], 32'h0);
    end
    nRST = 1'b1;

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < NW; i++) txn(k, 1'b0, 1'b1, 32'(i * 4), $urandom);
      idle(k);
    end

    // LAT=2 write then read
    txn(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF);
    idle(0);
    txn(0, 1'b1, 1'b0, 32'h40, 32'h0);
    chk("deadbeef", ld[0], 32'hDEADBEEF);
    idle(0);

    // LAT=0 streaming reads with REN held
    txn(1, 1'b0, 1'b1, 32'h0, 32'd1);
    txn(1, 1'b0, 1'b1, 32'h4, 32'd2);
    txn(1, 1'b0, 1'b1, 32'h8, 32'd3);
    idle(1);
    txn(1, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("stream0", ld[1], 32'd1);
    txn(1, 1'b1, 1'b0, 32'h4, 32'h0);
    chk("stream1", ld[1], 32'd2);
    txn(1, 1'b1, 1'b0, 32'h8, 32'h0);
    chk("stream2", ld[1], 32'd3);
    idle(1);

    // illegal requests leave memory alone
    txn(0, 1'b1, 1'b0, 32'h42, 32'h0);
    idle(0);
    txn(0, 1'b1, 1'b1, 32'h40, 32'h12345678);
    idle(0);
    txn(0, 1'b0, 1'b1, 32'h4000, 32'h0BADF00D);
    idle(0);
    txn(0, 1'b1, 1'b0, 32'h40, 32'h0);
    chk("err_mem", ld[0], 32'hDEADBEEF);
    idle(0);

    // LAT=3 restart on address change
    txn(2, 1'b0, 1'b1, 32'h10, 32'h1010);
    txn(2, 1'b0, 1'b1, 32'h20, 32'h2020);
    idle(2);
    ren[2] = 1'b1; addr[2] = 32'h10; store[2] = '0;
    step(); chk("rs busy1", st[2], BUSY);
    step(); chk("rs busy2", st[2], BUSY);
    addr[2] = 32'h20;
    for (int i = 0; i < 3; i++) begin
      step(); chk("rs busy_more", st[2], BUSY);
    end
    step(); chk("rs access", st[2], ACCESS);
    chk("rs data", ld[2], 32'h2020);
    last_ld[2] = 32'h2020;
    idle(2);

    // abort a write mid-BUSY
    wen[2] = 1'b1; addr[2] = 32'h10; store[2] = 32'h77777777;
    step(); chk("drop busy", st[2], BUSY);
    wen[2] = 1'b0;
    step(); chk("drop free", st[2], FREE);
    txn(2, 1'b1, 1'b0, 32'h10, 32'h0);
    chk("drop mem", ld[2], 32'h1010);
    idle(2);

    // reset mid-BUSY drops the write
    txn(0, 1'b1, 1'b0, 32'h100, 32'h0);
    idle(0);
    wen[0] = 1'b1; addr[0] = 32'h100; store[0] = 32'hA5A5A5A5;
    step(); chk("rst busy", st[0], BUSY);
    #2 nRST = 1'b0;
    #1;
    chk("rst now state", st[0], FREE);
    chk("rst now load", ld[0], 32'h0);
    wen[0] = 1'b0;
    for (int k = 0; k < 3; k++) last_ld[k] = '0;
    @(negedge CLK);
    nRST = 1'b1;
    txn(0, 1'b1, 1'b0, 32'h100, 32'h0);
    idle(0);

    // reset during a write ACCESS drops it too
    wen[0] = 1'b1; addr[0] = 32'h104; store[0] = 32'hBAD0BAD0;
    step(); chk("rsta busy1", st[0], BUSY);
    step(); chk("rsta busy2", st[0], BUSY);
    step(); chk("rsta access", st[0], ACCESS);
    #2 nRST = 1'b0;
    #1 chk("rsta state", st[0], FREE);
    wen[0] = 1'b0;
    for (int k = 0; k < 3; k++) last_ld[k] = '0;
    @(negedge CLK);
    nRST = 1'b1;
    txn(0, 1'b1, 1'b0, 32'h104, 32'h0);
    idle(0);

    // write then read with no gap
    txn(1, 1'b0, 1'b1, 32'h30, 32'h11);
    txn(1, 1'b1, 1'b0, 32'h30, 32'h0);
    chk("wr_rd lat0", ld[1], 32'h11);
    idle(1);
    txn(0, 1'b0, 1'b1, 32'h34, 32'h11);
    txn(0, 1'b1, 1'b0, 32'h34, 32'h0);
    chk("wr_rd lat2", ld[0], 32'h11);
    idle(0);

    // randomized traffic
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 60; n++) begin
        int unsigned sel;
        bit    r;
        bit    w;
        word_t a;
        sel = $urandom_range(0, 9);
        r   = 1'($urandom_range(0, 1));
        w   = !r;
        a   = 32'($urandom_range(0, NW - 1) * 4);
        if (sel == 0) a = a | 32'($urandom_range(1, 3));
        else if (sel == 1) a = a + 32'h4000;
        else if (sel == 2) begin r = 1'b1; w = 1'b1; end
        txn(k, r, w, a, $urandom);
        if ($urandom_range(0, 2) == 0) idle(k);
      end
      idle(k);
    end

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
